fwd_scoreboard: RTL and testbench

- Parametrised successor to the combinational forwarding unit. It holds its own shift register of in-flight destination tags, one entry per producer stage.
- Each cycle it computes a forwarding select for each of NUM_SRC source operands of the instruction in decode.
- It raises a load-use stall and inserts the bubble itself, and honours external hold and flush.
- It sits between decode and the EX operand muxes and replaces per-op special cases (CBZ/STUR/BR/BL) with a uniform multi-source, multi-depth rule.

---
 rtl/fwd_scoreboard.sv | 106 ++++++++++
 tb/tb_fwd_scoreboard.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight destination tags per producer stage, selects
// per-source forwarding, and inserts load-use bubbles. Optional FWD_SCOREBOARD_STATS_EN adds counters.
module fwd_scoreboard #(
    parameter int unsigned  REG_W    = 5,
    parameter int unsigned  DEPTH    = 3,
    parameter int unsigned  NUM_SRC  = 3,
    parameter int unsigned  ZERO_REG = 31,
    parameter int unsigned  LOAD_LAT = 1,
    localparam int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     issue_valid,
    input  logic [REG_W-1:0]         issue_rd,
    input  logic                     issue_regwrite,
    input  logic                     issue_memread,
    input  logic [NUM_SRC*REG_W-1:0] src_reg,
    input  logic [NUM_SRC-1:0]       src_used,
    input  logic                     hold_in,
    input  logic                     flush,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic                     stall_out
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    output logic [15:0]              stall_cnt,
    output logic [15:0]              fwd_cnt
`endif
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } stage_t;

    stage_t             stage_q [DEPTH];
    stage_t             issue_ent;
    logic [NUM_SRC-1:0] slot_stall;
    logic               capture;

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        fwd_sel    = '0;
        slot_stall = '0;
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                if (stage_q[i].valid && stage_q[i].regwrite && src_used[s] &&
                    stage_q[i].rd == src_reg[s*REG_W +: REG_W] &&
                    src_reg[s*REG_W +: REG_W] != REG_W'(ZERO_REG)) begin
                    fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(i + 1);
                    slot_stall[s]             = stage_q[i].memread && (i < int'(LOAD_LAT));
                end
            end
        end
    end

    assign stall_out = issue_valid && !flush && !hold_in && (|slot_stall);
    assign capture   = issue_valid && !stall_out && !flush;

    always_comb begin
        issue_ent = '0;
        if (capture) begin
            issue_ent.valid    = 1'b1;
            issue_ent.rd       = issue_rd;
            issue_ent.regwrite = issue_regwrite;
            issue_ent.memread  = issue_memread;
        end
    end

    // Hold freezes every stage; a flush during hold still squashes the youngest entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else if (hold_in) begin
            if (flush) begin
                stage_q[0] <= '0;
            end
        end else begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                stage_q[i] <= stage_q[i-1];
            end
            stage_q[0] <= issue_ent;
        end
    end

`ifdef FWD_SCOREBOARD_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall_out && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (!hold_in && capture && (|fwd_sel) && fwd_cnt != 16'hFFFF) begin
                fwd_cnt <= fwd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed vector table, async-reset corner and
// randomized traffic against a queue-based reference model.
module tb_fwd_scoreboard;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned DEPTH    = 3;
    localparam int unsigned NUM_SRC  = 3;
    localparam int unsigned ZERO_REG = 31;
    localparam int unsigned LOAD_LAT = 1;
    localparam int unsigned SEL_W    = 2;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     issue_valid;
    logic [REG_W-1:0]         issue_rd;
    logic                     issue_regwrite;
    logic                     issue_memread;
    logic [NUM_SRC*REG_W-1:0] src_reg;
    logic [NUM_SRC-1:0]       src_used;
    logic                     hold_in;
    logic                     flush;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     stall_out;
`ifdef FWD_SCOREBOARD_STATS_EN
    logic [15:0]              stall_cnt;
    logic [15:0]              fwd_cnt;
`endif

    fwd_scoreboard #(
        .REG_W(REG_W), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC),
        .ZERO_REG(ZERO_REG), .LOAD_LAT(LOAD_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_regwrite(issue_regwrite), .issue_memread(issue_memread),
        .src_reg(src_reg), .src_used(src_used),
        .hold_in(hold_in), .flush(flush),
        .fwd_sel(fwd_sel), .stall_out(stall_out)
`ifdef FWD_SCOREBOARD_STATS_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a list of in-flight producers, youngest at the front.
    typedef struct { bit valid; int rd; bit rw; bit mr; } ent_t;
    ent_t pipe[$];
    int   m_stall_cnt;
    int   m_fwd_cnt;

    typedef struct {
        logic       iv;
        logic [4:0] rd;
        logic       rw, mr;
        logic [4:0] s0, s1, s2;
        logic [2:0] used;
        logic       hold, fl;
        logic [1:0] e0, e1, e2;
        logic       est;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        ent_t b = '{0, 0, 0, 0};
        pipe.delete();
        for (int i = 0; i < int'(DEPTH); i++) pipe.push_back(b);
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
    endfunction

    // Depth+1 of the youngest producer writing this slot's register, 0 if none.
    function automatic int exp_slot(int s);
        int r = int'(src_reg[s*REG_W +: REG_W]);
        int hit = 0;
        if (!src_used[s] || r == int'(ZERO_REG)) return 0;
        for (int i = pipe.size() - 1; i >= 0; i--)
            if (pipe[i].valid && pipe[i].rw && pipe[i].rd == r) hit = i + 1;
        return hit;
    endfunction

    task automatic model_eval(output logic [5:0] sel, output logic st);
        sel = '0;
        st  = 1'b0;
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            int k = exp_slot(s);
            sel[s*SEL_W +: SEL_W] = 2'(k);
            if (k > 0 && pipe[k-1].mr && (k - 1) < int'(LOAD_LAT)) st = 1'b1;
        end
        if (!issue_valid || flush || hold_in) st = 1'b0;
    endtask

    task automatic model_step(input logic [5:0] sel, input logic st);
        ent_t e = '{0, 0, 0, 0};
        if (hold_in) begin
            if (flush) pipe[0] = e;
        end else begin
            if (issue_valid && !st && !flush) begin
                e = '{1, int'(issue_rd), issue_regwrite, issue_memread};
                if (sel != 0 && m_fwd_cnt < 65535) m_fwd_cnt++;
            end
            if (st && m_stall_cnt < 65535) m_stall_cnt++;
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
    endtask

    // Inputs are driven just after a rising edge; outputs compared at the falling edge.
    task automatic run_cycle(input string name, input bit use_tbl,
                             input logic [5:0] t_sel, input logic t_st);
        logic [5:0] m_sel;
        logic       m_st;
        @(negedge clk);
        model_eval(m_sel, m_st);
        if (use_tbl) begin
            chk({name, " fwd_sel"}, 32'(fwd_sel), 32'(t_sel));
            chk({name, " stall"}, 32'(stall_out), 32'(t_st));
        end else begin
            chk({name, " fwd_sel"}, 32'(fwd_sel), 32'(m_sel));
            chk({name, " stall"}, 32'(stall_out), 32'(m_st));
        end
        @(posedge clk);
        model_step(m_sel, m_st);
        #1;
    endtask

    function automatic logic [4:0] rand_reg();
        return ($urandom % 6 == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    task automatic randomize_inputs();
        issue_valid    = ($urandom % 4) != 0;
        issue_rd       = rand_reg();
        issue_regwrite = ($urandom % 4) != 0;
        issue_memread  = ($urandom % 3) == 0;
        src_reg        = {rand_reg(), rand_reg(), rand_reg()};
        src_used       = 3'($urandom);
        hold_in        = ($urandom % 8) == 0;
        flush          = ($urandom % 10) == 0;
    endtask

    task automatic drive_vec(input vec_t v);
        issue_valid    = v.iv;
        issue_rd       = v.rd;
        issue_regwrite = v.rw;
        issue_memread  = v.mr;
        src_reg        = {v.s2, v.s1, v.s0};
        src_used       = v.used;
        hold_in        = v.hold;
        flush          = v.fl;
    endtask

    initial begin
        // iv rd rw mr | s0 s1 s2 used | hold flush | e0 e1 e2 stall
        tbl.push_back('{1,  3, 1, 0,   0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0}); // issue ADD rd=3
        tbl.push_back('{1, 10, 1, 0,   3, 0, 0, 3'b001, 0, 0, 1, 0, 0, 0}); // fwd from EX
        tbl.push_back('{1,  5, 1, 0,   3, 0, 0, 3'b001, 0, 0, 2, 0, 0, 0});
        tbl.push_back('{1,  5, 1, 0,   3, 0, 0, 3'b001, 0, 0, 3, 0, 0, 0});
        tbl.push_back('{0,  0, 0, 0,   5, 0, 0, 3'b001, 0, 0, 1, 0, 0, 0}); // younger rd=5 shadows
        tbl.push_back('{0,  0, 0, 0,   5, 0, 0, 3'b001, 0, 0, 2, 0, 0, 0});
        tbl.push_back('{1,  7, 1, 1,   5, 0, 0, 3'b001, 0, 0, 3, 0, 0, 0}); // LDUR rd=7
        tbl.push_back('{1, 12, 1, 0,   0, 7, 0, 3'b010, 0, 0, 0, 1, 0, 1}); // load-use stall
        tbl.push_back('{1, 12, 1, 0,   0, 7, 0, 3'b010, 0, 0, 0, 2, 0, 0}); // re-present, fwd=2
        tbl.push_back('{1, 31, 1, 0,  12, 0, 0, 3'b001, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1,  4, 1, 0,  31, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0}); // zero reg
        tbl.push_back('{1,  9, 1, 0,  12, 0, 4, 3'b001, 0, 0, 3, 0, 0, 0}); // unused slot 2
        tbl.push_back('{1, 20, 1, 0,   9, 0, 0, 3'b001, 1, 0, 1, 0, 0, 0}); // hold x3
        tbl.push_back('{1, 20, 1, 0,   9, 0, 0, 3'b001, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 20, 1, 0,   9, 0, 0, 3'b001, 1, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 20, 1, 0,   9, 0, 0, 3'b001, 1, 1, 1, 0, 0, 0}); // hold+flush
        tbl.push_back('{0,  0, 0, 0,   9, 4, 0, 3'b011, 0, 0, 0, 2, 0, 0}); // stage0 cleared
        tbl.push_back('{1,  8, 1, 1,   0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 13, 1, 0,   8, 0, 0, 3'b001, 0, 1, 1, 0, 0, 0}); // flush beats stall
        tbl.push_back('{1,  6, 1, 1,   8, 0, 0, 3'b001, 0, 0, 2, 0, 0, 0});
        tbl.push_back('{1, 14, 1, 0,   6, 0, 0, 3'b001, 1, 0, 1, 0, 0, 0}); // hold masks stall
        tbl.push_back('{1, 14, 1, 0,   6, 0, 0, 3'b001, 0, 0, 1, 0, 0, 1});
        tbl.push_back('{1,  0, 0, 0,   6, 8, 0, 3'b011, 0, 0, 2, 0, 0, 0});
        tbl.push_back('{0,  0, 0, 0,   6, 0, 0, 3'b011, 0, 0, 3, 0, 0, 0}); // non-writer ignored
        tbl.push_back('{1,  2, 1, 1,   0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 15, 1, 0,   0, 0, 2, 3'b100, 0, 0, 0, 0, 1, 1}); // stall from slot 2
        tbl.push_back('{1, 15, 1, 0,   0, 0, 2, 3'b100, 0, 0, 0, 0, 2, 0});

        // Reset held with random inputs.
        reset_n = 1'b0;
        randomize_inputs();
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("reset fwd_sel", 32'(fwd_sel), 32'd0);
            chk("reset stall", 32'(stall_out), 32'd0);
            randomize_inputs();
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Directed vector table.
        for (int r = 0; r < tbl.size(); r++) begin
            string nm;
            nm = $sformatf("vec%0d", r);
            drive_vec(tbl[r]);
            run_cycle(nm, 1'b1, {tbl[r].e2, tbl[r].e1, tbl[r].e0}, tbl[r].est);
        end
`ifdef FWD_SCOREBOARD_STATS_EN
        chk("stall_cnt after table", 32'(stall_cnt), 32'd3);
        chk("fwd_cnt after table", 32'(fwd_cnt), 32'd10);
`endif

        // Asynchronous reset in the middle of a load-use stall.
        drive_vec('{1, 7, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0});
        run_cycle("mid load", 1'b0, '0, 1'b0);
        drive_vec('{1, 11, 1, 0, 7, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        chk("pre-reset stall", 32'(stall_out), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset stall", 32'(stall_out), 32'd0);
        chk("async reset fwd_sel", 32'(fwd_sel), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            randomize_inputs();
            run_cycle("rand", 1'b0, '0, 1'b0);
        end
`ifdef FWD_SCOREBOARD_STATS_EN
        chk("rand stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
        chk("rand fwd_cnt", 32'(fwd_cnt), 32'(m_fwd_cnt));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
